// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time, buffers returned words
// with their PCs in a small FIFO, and handles redirects and misaligned-target faults.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  pll_1_200MHz,
  input  logic                  system_reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  misaligned_fault
);

  localparam int                    PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pending_pc;
  logic                  discard;

  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic accept;
  logic redirect_taken;
  logic redirect_aligned;
  logic push;
  logic pop;
  logic flush;
  logic load_target;
  logic advance_pc;
  logic latch_pending;
  logic set_discard;
  logic clear_discard;
  logic set_fault;

  // Outputs are forced quiet while reset is held so nothing leaks out mid-reset.
  assign imem_req_valid   = !system_reset && (state == FETCH) && (count < DEPTH_CNT);
  assign imem_req_addr    = fetch_pc;
  assign inst_valid       = !system_reset && (state != HALT) && (count != '0);
  assign inst_pc          = fifo_pc[rd_ptr];
  assign inst_data        = fifo_data[rd_ptr];
  assign accept           = imem_req_valid && imem_req_ready;
  assign redirect_taken   = redirect_valid && (state != HALT);
  assign redirect_aligned = (redirect_target[1:0] == 2'b00);

  always_comb begin
    state_next    = state;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    load_target   = 1'b0;
    advance_pc    = 1'b0;
    latch_pending = 1'b0;
    set_discard   = 1'b0;
    clear_discard = 1'b0;
    set_fault     = 1'b0;

    if (redirect_taken) begin
      flush = 1'b1;
      if (!redirect_aligned) begin
        set_fault  = 1'b1;
        state_next = HALT;
      end else begin
        load_target = 1'b1;
        // A fetch still in flight after this edge must have its word thrown away.
        if (accept || ((state == WAIT) && !imem_resp_valid)) begin
          set_discard = 1'b1;
          state_next  = WAIT;
        end else begin
          clear_discard = 1'b1;
          state_next    = FETCH;
        end
      end
    end else begin
      pop = inst_valid && inst_ready;
      case (state)
        FETCH: begin
          if (accept) begin
            latch_pending = 1'b1;
            state_next    = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_next = FETCH;
            if (discard) begin
              clear_discard = 1'b1;
            end else begin
              push       = 1'b1;
              advance_pc = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge pll_1_200MHz) begin
    if (system_reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge pll_1_200MHz) begin
    if (system_reset) begin
      fetch_pc         <= RESET_VECTOR;
      pending_pc       <= RESET_VECTOR;
      discard          <= 1'b0;
      misaligned_fault <= 1'b0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
    end else begin
      if (load_target) begin
        fetch_pc <= redirect_target;
      end else if (advance_pc) begin
        fetch_pc <= pending_pc + PC_STEP;
      end

      if (latch_pending) begin
        pending_pc <= fetch_pc;
      end

      if (set_discard) begin
        discard <= 1'b1;
      end else if (clear_discard) begin
        discard <= 1'b0;
      end

      if (set_fault) begin
        misaligned_fault <= 1'b1;
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge pll_1_200MHz) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pending_pc;
      fifo_data[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_instruction_fetch_unit;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic          clk = 1'b0;
  logic          system_reset;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic          misaligned_fault;

  instruction_fetch_unit #(
    .ADDR_WIDTH  (AW),
    .RESET_VECTOR(RV),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .pll_1_200MHz    (clk),
    .system_reset    (system_reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model: instruction buffer as a queue plus a few abstract flags.
  entry_t      model_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_pending;
  bit          model_busy;
  bit          model_drop;
  bit          model_halt;
  bit          model_fault;

  // Memory environment: one response per accepted request after a random delay.
  bit          mem_pending;
  int          mem_delay;
  logic [31:0] mem_data;
  int          lat_min;
  int          lat_max;
  bit          spurious_en;

  int          compared;
  int          mismatched;
  int          cycle_no;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] pop_pc[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle_no);
    end
  endtask

  function automatic logic [63:0] accAt(input int i);
    if (i >= 0 && i < acc_addr.size()) return {32'h0, acc_addr[i]};
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  function automatic int cycAt(input int i);
    if (i >= 0 && i < acc_cyc.size()) return acc_cyc[i];
    return -100;
  endfunction

  function automatic logic [63:0] popAt(input int i);
    if (i >= 0 && i < pop_pc.size()) return {32'h0, pop_pc[i]};
    return 64'hBAD1_BAD1_BAD1_BAD1;
  endfunction

  task automatic clearObs();
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    cycle_no = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit rst, input bit ready, input bit iready,
                               input bit redir, input logic [31:0] tgt);
    bit          exp_req;
    bit          exp_inst;
    bit          accepted;
    bit          resp_now;
    bit          spur;
    bit          in_flight;
    logic [31:0] rdata;
    entry_t      e;

    exp_req  = !rst && !model_halt && !model_busy && (model_q.size() < DEPTH);
    exp_inst = !rst && !model_halt && (model_q.size() > 0);
    accepted = exp_req && ready;
    resp_now = mem_pending && (mem_delay == 0);
    spur     = 1'b0;
    if (spurious_en && !resp_now && !mem_pending && !model_busy && !accepted)
      spur = ($urandom_range(0, 9) == 0);
    rdata = resp_now ? mem_data : $urandom;

    system_reset    = rst;
    imem_req_ready  = ready;
    inst_ready      = iready;
    redirect_valid  = redir;
    redirect_target = tgt;
    imem_resp_valid = resp_now || spur;
    imem_resp_data  = rdata;
    #1;

    checkOutput("req_valid", imem_req_valid, exp_req);
    if (exp_req) checkOutput("req_addr", imem_req_addr, model_pc);
    checkOutput("inst_valid", inst_valid, exp_inst);
    if (exp_inst) begin
      checkOutput("inst_pc", inst_pc, model_q[0].pc);
      checkOutput("inst_data", inst_data, model_q[0].data);
    end
    checkOutput("fault", misaligned_fault, model_fault);

    if (imem_req_valid && imem_req_ready) begin
      acc_addr.push_back(imem_req_addr);
      acc_cyc.push_back(cycle_no);
    end
    if (inst_valid && inst_ready) pop_pc.push_back(inst_pc);

    if (resp_now) mem_pending = 1'b0;
    else if (mem_pending) mem_delay--;
    if (accepted) begin
      mem_pending = 1'b1;
      mem_delay   = $urandom_range(lat_min, lat_max);
      mem_data    = $urandom;
    end
    if (rst) mem_pending = 1'b0;

    if (rst) begin
      model_q.delete();
      model_pc    = RV;
      model_busy  = 1'b0;
      model_drop  = 1'b0;
      model_halt  = 1'b0;
      model_fault = 1'b0;
    end else if (!model_halt) begin
      if (redir) begin
        model_q.delete();
        if (tgt[1:0] != 2'b00) begin
          model_fault = 1'b1;
          model_halt  = 1'b1;
          model_busy  = 1'b0;
        end else begin
          in_flight  = accepted || (model_busy && !resp_now);
          model_busy = in_flight;
          model_drop = in_flight;
          model_pc   = tgt;
        end
      end else begin
        if (exp_inst && iready) void'(model_q.pop_front());
        if (accepted) begin
          model_busy    = 1'b1;
          model_pending = model_pc;
        end else if (model_busy && resp_now) begin
          model_busy = 1'b0;
          if (model_drop) begin
            model_drop = 1'b0;
          end else begin
            e.pc   = model_pending;
            e.data = rdata;
            model_q.push_back(e);
            model_pc = model_pending + 32'd4;
          end
        end
      end
    end

    cycle_no++;
    @(negedge clk);
  endtask

  initial begin
    int          n_before;
    int          p_before;
    bit          found;
    bit          rst;
    bit          redir;
    int          r;
    logic [31:0] tgt;

    compared    = 0;
    mismatched  = 0;
    cycle_no    = 0;
    model_pc    = RV;
    model_busy  = 1'b0;
    model_drop  = 1'b0;
    model_halt  = 1'b0;
    model_fault = 1'b0;
    mem_pending = 1'b0;
    mem_delay   = 0;
    mem_data    = '0;
    lat_min     = 0;
    lat_max     = 0;
    spurious_en = 1'b0;

    system_reset    = 1'b1;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    @(posedge clk);
    @(negedge clk);

    // Streaming with a one-cycle memory and an always-ready consumer.
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    clearObs();
    repeat (8) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("stream_addr0", accAt(0), 64'h0);
    checkOutput("stream_addr1", accAt(1), 64'h4);
    checkOutput("stream_addr2", accAt(2), 64'h8);
    checkOutput("stream_first_cycle", 64'(cycAt(0)), 64'(0));
    checkOutput("stream_spacing", 64'(cycAt(1) - cycAt(0)), 64'(2));
    checkOutput("stream_pop0", popAt(0), 64'h0);
    checkOutput("stream_pop1", popAt(1), 64'h4);
    checkOutput("stream_pop2", popAt(2), 64'h8);

    // Stalled consumer: the buffer fills, then a single pop frees one slot.
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    clearObs();
    repeat (20) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("full_fetches", 64'(acc_addr.size()), 64'(4));
    checkOutput("full_last_addr", accAt(3), 64'hC);
    checkOutput("full_req_idle", imem_req_valid, 1'b0);
    applyStimulus(0, 1, 1, 0, 0);
    repeat (6) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("refill_fetches", 64'(acc_addr.size()), 64'(5));
    checkOutput("refill_addr", accAt(4), 64'h10);

    // Redirect while waiting on the response for 0x8.
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    clearObs();
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 40 && !(acc_addr.size() > 0 && acc_addr[acc_addr.size()-1] == 32'h8); i++)
      applyStimulus(0, 1, 0, 0, 0);
    found = (acc_addr.size() > 0) && (acc_addr[acc_addr.size()-1] == 32'h8);
    checkOutput("redir_reach_8", found, 1'b1);
    n_before = acc_addr.size();
    p_before = pop_pc.size();
    applyStimulus(0, 1, 0, 1, 32'h100);
    repeat (12) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("redir_next_addr", accAt(n_before), 64'h100);
    checkOutput("redir_next_pc", popAt(p_before), 64'h100);

    // Misaligned redirect halts until reset; later redirects are ignored.
    lat_min = 0;
    lat_max = 0;
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'h102);
    clearObs();
    repeat (4) applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h200);
    repeat (5) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("halt_no_fetch", 64'(acc_addr.size()), 64'(0));
    checkOutput("halt_no_pop", 64'(pop_pc.size()), 64'(0));
    checkOutput("halt_fault", misaligned_fault, 1'b1);
    applyStimulus(1, 1, 1, 0, 0);
    clearObs();
    repeat (4) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("halt_resume_addr", accAt(0), {32'h0, RV});
    checkOutput("halt_fault_cleared", misaligned_fault, 1'b0);

    // Fetch PC wraps past the top of the address space.
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    clearObs();
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC);
    repeat (10) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("wrap_addr_top", accAt(1), 64'hFFFF_FFFC);
    checkOutput("wrap_addr_zero", accAt(2), 64'h0);
    checkOutput("wrap_pop_top", popAt(0), 64'hFFFF_FFFC);

    // Randomized traffic with variable latency, stalls, redirects, stray responses and resets.
    lat_min     = 0;
    lat_max     = 3;
    spurious_en = 1'b1;
    repeat (2) applyStimulus(1, 1, 1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0) || (model_halt && $urandom_range(0, 19) == 0);
      r     = $urandom_range(0, 99);
      redir = (r < 4);
      if (r == 0 && $urandom_range(0, 3) == 0)
        tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (r == 1)
        tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else
        tgt = $urandom & 32'hFFFF_FFFC;
      applyStimulus(rst, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, redir, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
